// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches. Resolves the oldest entry, reports the
// outcome one cycle later and redirects fetch (discarding wrong-path entries) on a mispredict.
module branch_resolve_queue #(
    parameter  int XLEN      = 32,
    parameter  int DEPTH     = 4,
    parameter  int BR_CTRL_W = 3,
    localparam int CNT_W     = $clog2(DEPTH + 1),
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 flush,
    input  logic                 enqValid,
    output logic                 enqReady,
    input  logic [XLEN-1:0]      enqPc,
    input  logic                 enqPredTaken,
    input  logic [XLEN-1:0]      enqPredTarget,
    input  logic                 resValid,
    input  logic [BR_CTRL_W-1:0] resCtrl,
    input  logic [XLEN-1:0]      resRs1,
    input  logic [XLEN-1:0]      resRs2,
    input  logic [XLEN-1:0]      resBase,
    input  logic [XLEN-1:0]      resOffset,
    input  logic                 resIsJalr,
    output logic                 redirectValid,
    output logic [XLEN-1:0]      redirectPc,
    output logic                 updValid,
    output logic [XLEN-1:0]      updPc,
    output logic                 updTaken,
    output logic [XLEN-1:0]      updTarget,
    output logic                 updMispredict,
    output logic [CNT_W-1:0]     count,
    output logic                 o_dbg_state
);

    // Handshakes: an enqueue happens on a rising edge where enqValid && enqReady;
    // a resolution is consumed on an edge where resValid is high, the queue is
    // non-empty and the FSM is in RUN. There is no backpressure on resolution.

    localparam logic [BR_CTRL_W-1:0] BR_EQ   = BR_CTRL_W'(0);
    localparam logic [BR_CTRL_W-1:0] BR_NE   = BR_CTRL_W'(1);
    localparam logic [BR_CTRL_W-1:0] BR_LT   = BR_CTRL_W'(2);
    localparam logic [BR_CTRL_W-1:0] BR_GE   = BR_CTRL_W'(3);
    localparam logic [BR_CTRL_W-1:0] BR_LTU  = BR_CTRL_W'(4);
    localparam logic [BR_CTRL_W-1:0] BR_GEU  = BR_CTRL_W'(5);
    localparam logic [BR_CTRL_W-1:0] BR_JUMP = BR_CTRL_W'(6);

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [XLEN-1:0]  r_pc        [DEPTH];
    logic             r_pred_taken[DEPTH];
    logic [XLEN-1:0]  r_pred_tgt  [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;
    logic            r_upd_valid;
    logic [XLEN-1:0] r_upd_pc;
    logic            r_upd_taken;
    logic [XLEN-1:0] r_upd_target;
    logic            r_upd_mispredict;

    logic            w_enq_fire;
    logic            w_res_fire;
    logic            w_taken;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_next_pc;
    logic            w_mispredict;

    assign enqReady   = (r_state == RUN) && (r_count < CNT_W'(DEPTH));
    assign w_enq_fire = enqValid && enqReady;
    assign w_res_fire = resValid && (r_count != '0) && (r_state == RUN);

    always_comb begin
        w_taken = 1'b0;
        case (resCtrl)
            BR_EQ:   w_taken = (resRs1 == resRs2);
            BR_NE:   w_taken = (resRs1 != resRs2);
            BR_LT:   w_taken = ($signed(resRs1) < $signed(resRs2));
            BR_GE:   w_taken = !($signed(resRs1) < $signed(resRs2));
            BR_LTU:  w_taken = (resRs1 < resRs2);
            BR_GEU:  w_taken = !(resRs1 < resRs2);
            BR_JUMP: w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    assign w_target     = (resBase + resOffset) & ~{{(XLEN-1){1'b0}}, resIsJalr};
    assign w_next_pc    = w_taken ? w_target : (r_pc[r_head] + XLEN'(4));
    assign w_mispredict = w_res_fire &&
                          ((r_pred_taken[r_head] != w_taken) ||
                           (w_taken && (r_pred_tgt[r_head] != w_target)));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:      if (w_mispredict) w_state_next = REDIRECT;
            REDIRECT: w_state_next = RUN;
            default:  w_state_next = RUN;
        endcase
        if (flush) w_state_next = RUN;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) r_state <= RUN;
        else       r_state <= w_state_next;
    end

    // Entry payload needs no reset: occupancy is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_enq_fire && !w_mispredict && !flush) begin
            r_pc[r_tail]         <= enqPc;
            r_pred_taken[r_tail] <= enqPredTaken;
            r_pred_tgt[r_tail]   <= enqPredTarget;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_upd_valid      <= 1'b0;
            r_upd_pc         <= '0;
            r_upd_taken      <= 1'b0;
            r_upd_target     <= '0;
            r_upd_mispredict <= 1'b0;
        end else if (flush) begin
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            r_redirect_valid <= 1'b0;
            r_upd_valid      <= 1'b0;
        end else begin
            r_upd_valid      <= w_res_fire;
            r_redirect_valid <= w_mispredict;
            if (w_res_fire) begin
                r_upd_pc         <= r_pc[r_head];
                r_upd_taken      <= w_taken;
                r_upd_target     <= w_target;
                r_upd_mispredict <= w_mispredict;
            end
            if (w_mispredict) r_redirect_pc <= w_next_pc;

            // A mispredict squashes every younger entry, including a same-edge enqueue.
            if (w_mispredict) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_enq_fire) r_tail <= r_tail + PTR_W'(1);
                if (w_res_fire) r_head <= r_head + PTR_W'(1);
                case ({w_enq_fire, w_res_fire})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign redirectValid = r_redirect_valid;
    assign redirectPc    = r_redirect_pc;
    assign updValid      = r_upd_valid;
    assign updPc         = r_upd_pc;
    assign updTaken      = r_upd_taken;
    assign updTarget     = r_upd_target;
    assign updMispredict = r_upd_mispredict;
    assign count         = r_count;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios followed by random traffic,
// every cycle compared with a queue-based behavioural model.
module tb_branch_resolve_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int BW    = 3;

    logic            clk = 1'b0;
    logic            rstN;
    logic            flush;
    logic            enqValid;
    logic            enqReady;
    logic [XLEN-1:0] enqPc;
    logic            enqPredTaken;
    logic [XLEN-1:0] enqPredTarget;
    logic            resValid;
    logic [BW-1:0]   resCtrl;
    logic [XLEN-1:0] resRs1;
    logic [XLEN-1:0] resRs2;
    logic [XLEN-1:0] resBase;
    logic [XLEN-1:0] resOffset;
    logic            resIsJalr;
    logic            redirectValid;
    logic [XLEN-1:0] redirectPc;
    logic            updValid;
    logic [XLEN-1:0] updPc;
    logic            updTaken;
    logic [XLEN-1:0] updTarget;
    logic            updMispredict;
    logic [2:0]      count;
    logic            o_dbg_state;

    branch_resolve_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .BR_CTRL_W(BW)) dut (
        .clk(clk), .rstN(rstN), .flush(flush),
        .enqValid(enqValid), .enqReady(enqReady), .enqPc(enqPc),
        .enqPredTaken(enqPredTaken), .enqPredTarget(enqPredTarget),
        .resValid(resValid), .resCtrl(resCtrl), .resRs1(resRs1), .resRs2(resRs2),
        .resBase(resBase), .resOffset(resOffset), .resIsJalr(resIsJalr),
        .redirectValid(redirectValid), .redirectPc(redirectPc),
        .updValid(updValid), .updPc(updPc), .updTaken(updTaken),
        .updTarget(updTarget), .updMispredict(updMispredict),
        .count(count), .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
    } ent_t;

    ent_t        mq[$];
    bit          m_redir;
    bit          e_uv, e_ut, e_um, e_rv;
    logic [31:0] e_upc, e_utgt, e_rpc;

    function automatic bit signed_lt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) return a[31];
        return a < b;
    endfunction

    function automatic bit act_taken(input int ctrl, input logic [31:0] a, input logic [31:0] b);
        case (ctrl)
            0: return a == b;
            1: return a != b;
            2: return signed_lt(a, b);
            3: return !signed_lt(a, b);
            4: return a < b;
            5: return a >= b;
            6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        m_redir = 0;
        e_uv = 0; e_rv = 0;
    endtask

    task automatic cycle();
        bit          ready;
        bit          fire;
        bit          tk;
        bit          mis;
        logic [31:0] tgt;
        ent_t        h;
        ent_t        n;
        ready = !m_redir && (mq.size() < DEPTH);
        check_eq("enq_ready", enqReady, ready);
        n.pc = enqPc; n.pt = enqPredTaken; n.tgt = enqPredTarget;
        if (flush) begin
            mq.delete();
            m_redir = 0; e_uv = 0; e_rv = 0;
        end else begin
            fire = resValid && (mq.size() > 0) && !m_redir;
            e_uv = fire; e_rv = 0; mis = 0;
            if (fire) begin
                h   = mq[0];
                tk  = act_taken(int'(resCtrl), resRs1, resRs2);
                tgt = resBase + resOffset;
                if (resIsJalr) tgt[0] = 1'b0;
                mis = (h.pt != tk) || (tk && h.tgt != tgt);
                e_upc = h.pc; e_ut = tk; e_utgt = tgt; e_um = mis;
                if (mis) begin
                    mq.delete();
                    e_rv = 1;
                    e_rpc = tk ? tgt : h.pc + 32'd4;
                end else begin
                    void'(mq.pop_front());
                end
            end
            if (!mis && enqValid && ready) mq.push_back(n);
            m_redir = mis;
        end
        @(posedge clk);
        #1;
        check_eq("upd_valid", updValid, e_uv);
        if (e_uv) begin
            check_eq("upd_pc", updPc, e_upc);
            check_eq("upd_taken", updTaken, e_ut);
            check_eq("upd_target", updTarget, e_utgt);
            check_eq("upd_mispredict", updMispredict, e_um);
        end
        check_eq("redirect_valid", redirectValid, e_rv);
        if (e_rv) check_eq("redirect_pc", redirectPc, e_rpc);
        check_eq("count", count, mq.size());
        check_eq("state_redirect", o_dbg_state, m_redir);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        flush = 0; enqValid = 0; enqPc = '0; enqPredTaken = 0; enqPredTarget = '0;
        resValid = 0; resCtrl = 3'd7; resRs1 = '0; resRs2 = '0;
        resBase = '0; resOffset = '0; resIsJalr = 0;
    endtask

    task automatic set_enq(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        enqValid = 1; enqPc = pc; enqPredTaken = pt; enqPredTarget = tgt;
    endtask

    task automatic set_res(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] base, input logic [31:0] off, input logic jalr);
        resValid = 1; resCtrl = ctrl; resRs1 = a; resRs2 = b;
        resBase = base; resOffset = off; resIsJalr = jalr;
    endtask

    task automatic async_reset_pulse();
        #2 rstN = 0;
        #1;
        check_eq("arst_redirect_valid", redirectValid, 1'b0);
        check_eq("arst_upd_valid", updValid, 1'b0);
        check_eq("arst_count", count, 3'd0);
        check_eq("arst_state", o_dbg_state, 1'b0);
        #1 rstN = 1;
        model_reset();
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7fff_ffff;
            3: return 32'h8000_0000;
            4: return 32'hffff_ffff;
            default: return $urandom_range(0, 3);
        endcase
    endfunction

    task automatic rand_inputs();
        set_idle();
        flush    = ($urandom_range(0, 39) == 0);
        enqValid = $urandom_range(0, 1);
        enqPc    = 32'h1000 + ($urandom_range(0, 255) << 2);
        enqPredTaken  = $urandom_range(0, 1);
        enqPredTarget = enqPc + ($urandom_range(0, 15) << 2);
        resValid = ($urandom_range(0, 2) != 0);
        resRs1 = pick_operand(); resRs2 = pick_operand();
        if (mq.size() > 0 && $urandom_range(0, 9) < 7) begin
            if (mq[0].pt) begin
                resCtrl = 3'd6; resBase = mq[0].tgt; resOffset = '0;
            end else begin
                resCtrl = 3'd7; resBase = $urandom; resOffset = $urandom;
            end
        end else begin
            resCtrl   = 3'($urandom_range(0, 7));
            resBase   = 32'h1000 + ($urandom_range(0, 255) << 2);
            resOffset = $urandom_range(0, 7);
            resIsJalr = $urandom_range(0, 1);
        end
    endtask

    // ---------------- scenarios ----------------
    initial begin
        set_idle();
        rstN = 0;
        model_reset();
        #1;
        check_eq("rst_upd_valid", updValid, 1'b0);
        check_eq("rst_redirect_valid", redirectValid, 1'b0);
        check_eq("rst_count", count, 3'd0);
        check_eq("rst_upd_pc", updPc, 32'h0);
        check_eq("rst_redirect_pc", redirectPc, 32'h0);
        @(posedge clk); @(negedge clk);
        rstN = 1;
        @(posedge clk); #1;

        // correct prediction
        set_enq(32'h100, 1, 32'h140); cycle();
        set_idle(); set_res(3'd0, 32'd5, 32'd5, 32'h100, 32'h40, 0); cycle();
        set_idle(); cycle();

        // mispredict squashes younger entries; signed LT across the sign boundary
        set_enq(32'h200, 0, 32'h0); cycle();
        set_enq(32'h204, 1, 32'h300); cycle();
        set_enq(32'h208, 0, 32'h0); cycle();
        set_idle(); set_res(3'd2, 32'h8000_0000, 32'h1, 32'h200, 32'h20, 0);
        set_enq(32'h20c, 0, 32'h0); cycle();
        set_idle(); set_enq(32'h210, 0, 32'h0); cycle();
        check_eq("redirect_pc_0x220", redirectPc, 32'h220);
        set_idle(); cycle();

        // full queue, resolve with a blocked enqueue, then wrap-around order
        set_idle(); cycle();
        for (int i = 0; i < DEPTH; i++) begin
            set_enq(32'h300 + 32'(i * 4), 0, 32'h0); cycle();
        end
        set_idle(); set_enq(32'h310, 0, 32'h0); set_res(3'd7, 0, 0, 0, 0, 0); cycle();
        set_idle(); set_enq(32'h310, 0, 32'h0); cycle();
        for (int i = 0; i < DEPTH; i++) begin
            set_idle(); set_res(3'd1, 32'd3, 32'd3, 0, 0, 0); cycle();
        end

        // JALR target bit 0 cleared
        set_idle(); set_enq(32'h1000, 1, 32'h1006); cycle();
        set_idle(); set_res(3'd6, 0, 0, 32'h1003, 32'h4, 1); cycle();
        set_idle(); set_enq(32'h1000, 1, 32'h1007); cycle();
        set_idle(); set_res(3'd6, 0, 0, 32'h1003, 32'h4, 1); cycle();
        set_idle(); cycle();

        // flush beats a mispredicting resolution
        set_idle(); set_enq(32'h400, 0, 32'h0); cycle();
        set_enq(32'h404, 0, 32'h0); cycle();
        set_idle(); set_res(3'd0, 32'd5, 32'd5, 32'h400, 32'h10, 0); flush = 1; cycle();
        set_idle(); cycle();

        // asynchronous reset while in REDIRECT
        set_enq(32'h500, 0, 32'h0); cycle();
        set_idle(); set_res(3'd6, 0, 0, 32'h500, 32'h8, 0); cycle();
        set_idle();
        async_reset_pulse();
        cycle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            cycle();
        end
        set_idle(); cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
